// File: rtl/us_alarm_if.sv
// Arm/cancel request bundle for us_alarm.
//   cfg_valid    : arm request, qualifies cfg_deadline/cfg_period
//   cfg_ready    : block can accept an arm request
//   cfg_deadline : absolute microsecond time of the first expiry
//   cfg_period   : reload interval in us, 0 = one-shot
//   cfg_cancel   : disarm request (pulse or level)
interface us_alarm_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_deadline;
    logic [31:0] cfg_period;
    logic        cfg_cancel;

    modport master (
        output cfg_valid,
        output cfg_deadline,
        output cfg_period,
        output cfg_cancel,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_deadline,
        input  cfg_period,
        input  cfg_cancel,
        output cfg_ready
    );
endinterface

// File: rtl/us_alarm.sv
// Microsecond alarm: one-shot or periodic expiry against a free-running
// 32-bit microsecond count, with sticky pending flag and saturating miss count.
//   clk, rst_n : clock, synchronous active-low reset
//   us_now     : free-running microsecond timebase (wraps mod 2^32)
//   cfg        : arm/cancel request bundle (slave side)
//   ack        : clears pending
//   armed      : alarm is armed
//   fire       : one-clk pulse per expiry
//   pending    : sticky expiry flag awaiting ack
//   fire_time  : us_now sampled at the most recent expiry
//   miss_cnt   : expiries seen while pending was already set (saturating)
module us_alarm #(
    parameter int unsigned MISS_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       us_now,
    us_alarm_if.slave         cfg,
    input  logic              ack,
    output logic              armed,
    output logic              fire,
    output logic              pending,
    output logic [31:0]       fire_time,
    output logic [MISS_W-1:0] miss_cnt
);

    localparam int unsigned TIME_W = 32;
    localparam logic [MISS_W-1:0] MISS_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [TIME_W-1:0]   deadline_q;
    logic [TIME_W-1:0]   deadline_d;
    logic [TIME_W-1:0]   period_q;
    logic [TIME_W-1:0]   period_d;
    logic                ready_q;
    logic                fire_d;
    logic                pending_d;
    logic [TIME_W-1:0]   fire_time_d;
    logic [MISS_W-1:0]   miss_d;

    logic                accept_c;
    logic [TIME_W-1:0]   elapsed_c;
    logic                expire_c;

    assign cfg.cfg_ready = ready_q;
    assign armed         = (state_q == ARMED);

    // Cancel outranks an arm request, which outranks an expiry.
    assign accept_c  = cfg.cfg_valid && ready_q && !cfg.cfg_cancel;
    // Sign of the modular difference decides expiry, so the wrap is handled.
    assign elapsed_c = us_now - deadline_q;
    assign expire_c  = (state_q == ARMED) && !elapsed_c[TIME_W-1]
                       && !cfg.cfg_cancel && !accept_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (cfg.cfg_cancel) begin
            state_d = IDLE;
        end else if (accept_c) begin
            state_d = ARMED;
        end else if (expire_c && (period_q == '0)) begin
            state_d = IDLE;
        end
    end

    // Output and datapath next values.
    always_comb begin
        deadline_d  = deadline_q;
        period_d    = period_q;
        fire_d      = 1'b0;
        pending_d   = pending;
        fire_time_d = fire_time;
        miss_d      = miss_cnt;

        if (accept_c) begin
            deadline_d = cfg.cfg_deadline;
            period_d   = cfg.cfg_period;
            miss_d     = '0;
        end

        if (expire_c) begin
            fire_d      = 1'b1;
            pending_d   = 1'b1;
            fire_time_d = us_now;
            // Reload; a still-expired reload fires again next edge (catch-up).
            deadline_d  = deadline_q + period_q;
            if (pending && !ack && (miss_cnt != MISS_MAX)) begin
                miss_d = miss_cnt + MISS_W'(1);
            end
        end else if (ack) begin
            pending_d = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            deadline_q <= '0;
            period_q   <= '0;
            ready_q    <= 1'b0;
            fire       <= 1'b0;
            pending    <= 1'b0;
            fire_time  <= '0;
            miss_cnt   <= '0;
        end else begin
            deadline_q <= deadline_d;
            period_q   <= period_d;
            ready_q    <= 1'b1;
            fire       <= fire_d;
            pending    <= pending_d;
            fire_time  <= fire_time_d;
            miss_cnt   <= miss_d;
        end
    end

endmodule

// File: tb/tb_us_alarm.sv
// Self-checking bench for us_alarm: vector table, directed corner sequences
// and randomized traffic against a behavioural model. Two instances run in
// lockstep: default MISS_W and MISS_W=2 for saturation.
module tb_us_alarm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] us_now;
    logic        cfg_valid;
    logic        cfg_cancel;
    logic [31:0] cfg_deadline;
    logic [31:0] cfg_period;
    logic        ack;

    us_alarm_if if8();
    us_alarm_if if2();

    assign if8.cfg_valid    = cfg_valid;
    assign if8.cfg_cancel   = cfg_cancel;
    assign if8.cfg_deadline = cfg_deadline;
    assign if8.cfg_period   = cfg_period;
    assign if2.cfg_valid    = cfg_valid;
    assign if2.cfg_cancel   = cfg_cancel;
    assign if2.cfg_deadline = cfg_deadline;
    assign if2.cfg_period   = cfg_period;

    logic        armed8, fire8, pend8, armed2, fire2, pend2;
    logic [31:0] ft8, ft2;
    logic [7:0]  miss8;
    logic [1:0]  miss2;

    us_alarm dut8 (
        .clk(clk), .rst_n(rst_n), .us_now(us_now), .cfg(if8), .ack(ack),
        .armed(armed8), .fire(fire8), .pending(pend8),
        .fire_time(ft8), .miss_cnt(miss8)
    );

    us_alarm #(.MISS_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .us_now(us_now), .cfg(if2), .ack(ack),
        .armed(armed2), .fire(fire2), .pending(pend2),
        .fire_time(ft2), .miss_cnt(miss2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: alarm described by its rules, not by a state machine.
    logic        m_armed, m_fire, m_pend, m_ready;
    logic [31:0] m_dl, m_per, m_ft;
    int          m_miss8, m_miss2;

    task automatic model_edge();
        logic [31:0] diff;
        logic        due;
        diff = us_now - m_dl;
        due  = m_armed && ($signed(diff) >= 0);
        m_fire = 1'b0;
        if (!rst_n) begin
            m_armed = 0; m_pend = 0; m_ready = 0; m_dl = 0; m_per = 0;
            m_ft = 0; m_miss8 = 0; m_miss2 = 0;
            return;
        end
        if (cfg_cancel) begin
            m_armed = 0;
            if (ack) m_pend = 0;
        end else if (cfg_valid && m_ready) begin
            m_armed = 1; m_dl = cfg_deadline; m_per = cfg_period;
            m_miss8 = 0; m_miss2 = 0;
            if (ack) m_pend = 0;
        end else if (due) begin
            m_fire = 1;
            m_ft   = us_now;
            if (m_pend && !ack) begin
                if (m_miss8 < 255) m_miss8++;
                if (m_miss2 < 3)   m_miss2++;
            end
            m_pend = 1;
            if (m_per == 0) m_armed = 0;
            else            m_dl = m_dl + m_per;
        end else if (ack) begin
            m_pend = 0;
        end
        m_ready = 1;
    endtask

    task automatic compare_all();
        chk("armed8", 32'(armed8), 32'(m_armed));
        chk("fire8",  32'(fire8),  32'(m_fire));
        chk("pend8",  32'(pend8),  32'(m_pend));
        chk("ready8", 32'(if8.cfg_ready), 32'(m_ready));
        chk("ft8",    ft8, m_ft);
        chk("miss8",  32'(miss8), 32'(m_miss8));
        chk("armed2", 32'(armed2), 32'(m_armed));
        chk("fire2",  32'(fire2),  32'(m_fire));
        chk("pend2",  32'(pend2),  32'(m_pend));
        chk("ready2", 32'(if2.cfg_ready), 32'(m_ready));
        chk("ft2",    ft2, m_ft);
        chk("miss2",  32'(miss2), 32'(m_miss2));
    endtask

    // One clock edge: model follows the edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        cfg_valid = 0; cfg_cancel = 0; ack = 0;
    endtask

    typedef struct {
        logic [31:0] us;
        logic        valid;
        logic [31:0] dl;
        logic [31:0] per;
        logic        cancel;
        logic        ack;
        logic        e_armed;
        logic        e_fire;
        logic        e_pend;
        logic [31:0] e_ft;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] fq [$];
    int          nfire;

    initial begin
        // One-shot at 100, ack, then cancel racing an arm request.
        vecs[0] = '{32'd98,  1, 32'd100, 0, 0, 0, 1, 0, 0, 32'd0};
        vecs[1] = '{32'd99,  0, 0,       0, 0, 0, 1, 0, 0, 32'd0};
        vecs[2] = '{32'd100, 0, 0,       0, 0, 0, 0, 1, 1, 32'd100};
        vecs[3] = '{32'd101, 0, 0,       0, 0, 0, 0, 0, 1, 32'd100};
        vecs[4] = '{32'd102, 0, 0,       0, 0, 1, 0, 0, 0, 32'd100};
        vecs[5] = '{32'd103, 0, 0,       0, 0, 0, 0, 0, 0, 32'd100};
        vecs[6] = '{32'd104, 1, 32'd106, 0, 0, 0, 1, 0, 0, 32'd100};
        vecs[7] = '{32'd105, 1, 32'd105, 0, 1, 0, 0, 0, 0, 32'd100};
        vecs[8] = '{32'd106, 0, 0,       0, 0, 0, 0, 0, 0, 32'd100};

        rst_n = 0; us_now = 0; cfg_deadline = 0; cfg_period = 0;
        idle_inputs();
        step();
        step();
        rst_n = 1;
        step();
        chk("ready_after_reset", 32'(if8.cfg_ready), 32'd1);

        for (int i = 0; i < 9; i++) begin
            us_now = vecs[i].us; cfg_valid = vecs[i].valid;
            cfg_deadline = vecs[i].dl; cfg_period = vecs[i].per;
            cfg_cancel = vecs[i].cancel; ack = vecs[i].ack;
            step();
            chk($sformatf("vec%0d_armed", i), 32'(armed8), 32'(vecs[i].e_armed));
            chk($sformatf("vec%0d_fire", i),  32'(fire8),  32'(vecs[i].e_fire));
            chk($sformatf("vec%0d_pend", i),  32'(pend8),  32'(vecs[i].e_pend));
            chk($sformatf("vec%0d_ft", i),    ft8, vecs[i].e_ft);
        end
        idle_inputs();

        // Periodic across the 32-bit wrap.
        us_now = 32'hFFFF_FFFC; cfg_valid = 1; cfg_deadline = 32'hFFFF_FFFE; cfg_period = 3;
        step();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            us_now = us_now + 1;
            step();
            if (fire8) fq.push_back(ft8);
        end
        chk("wrap_nfire", 32'(fq.size()), 32'd3);
        if (fq.size() == 3) begin
            chk("wrap_ft0", fq[0], 32'hFFFF_FFFE);
            chk("wrap_ft1", fq[1], 32'h0000_0001);
            chk("wrap_ft2", fq[2], 32'h0000_0004);
        end
        chk("wrap_armed", 32'(armed8), 32'd1);

        // Misses and saturation: period 5, expiries at 12,17,...,37 unacked.
        cfg_cancel = 1; ack = 1;
        step();
        idle_inputs();
        us_now = 10; cfg_valid = 1; cfg_deadline = 12; cfg_period = 5;
        step();
        idle_inputs();
        nfire = 0;
        for (int i = 0; i < 27; i++) begin
            us_now = us_now + 1;
            step();
            if (fire8) begin
                nfire++;
                if (nfire == 4) begin
                    chk("miss4_pend", 32'(pend8), 32'd1);
                    chk("miss4_cnt8", 32'(miss8), 32'd3);
                end
            end
        end
        chk("miss6_nfire", 32'(nfire), 32'd6);
        chk("miss6_cnt8",  32'(miss8), 32'd5);
        chk("miss6_cnt2",  32'(miss2), 32'd3);

        // Ack on the same edge as the expiry at 42.
        for (int i = 0; i < 5; i++) begin
            us_now = us_now + 1;
            ack = (us_now == 42);
            step();
        end
        ack = 0;
        chk("ackexp_fire", 32'(fire8), 32'd1);
        chk("ackexp_pend", 32'(pend8), 32'd1);
        chk("ackexp_miss", 32'(miss8), 32'd5);

        // Arm request on the same edge as the expiry at 47.
        for (int i = 0; i < 4; i++) begin
            us_now = us_now + 1;
            step();
        end
        us_now = 47; cfg_valid = 1; cfg_deadline = 60; cfg_period = 0;
        step();
        idle_inputs();
        chk("cfgexp_fire", 32'(fire8), 32'd0);
        chk("cfgexp_miss2", 32'(miss2), 32'd0);
        chk("cfgexp_armed", 32'(armed8), 32'd1);
        nfire = 0;
        for (int i = 0; i < 14; i++) begin
            us_now = us_now + 1;
            step();
            if (fire8) begin
                nfire++;
                chk("cfgexp_ft", ft8, 32'd60);
            end
        end
        chk("cfgexp_nfire", 32'(nfire), 32'd1);

        // Past deadline with catch-up: us_now held at 1000.
        us_now = 1000; cfg_valid = 1; cfg_deadline = 990; cfg_period = 4;
        step();
        idle_inputs();
        nfire = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (fire8) begin
                nfire++;
                chk("catch_ft", ft8, 32'd1000);
            end
        end
        chk("catch_nfire", 32'(nfire), 32'd3);
        us_now = 1001;
        step();
        chk("catch_1001", 32'(fire8), 32'd0);
        us_now = 1002;
        step();
        chk("catch_1002", 32'(fire8), 32'd1);

        // Reset one clk before the next deadline (1006), pending set.
        for (int i = 0; i < 3; i++) begin
            us_now = us_now + 1;
            step();
        end
        chk("rst_pre_pend", 32'(pend8), 32'd1);
        rst_n = 0;
        step();
        chk("rst_armed", 32'(armed8), 32'd0);
        chk("rst_ready", 32'(if8.cfg_ready), 32'd0);
        chk("rst_ft", ft8, 32'd0);
        rst_n = 1; us_now = 1006;
        step();
        chk("rst_post_fire", 32'(fire8), 32'd0);
        chk("rst_post_ready", 32'(if8.cfg_ready), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) us_now = us_now + 32'($urandom_range(0, 1000));
            else                            us_now = us_now + 32'($urandom_range(0, 1));
            cfg_valid    = ($urandom_range(0, 4) == 0);
            cfg_deadline = us_now + 32'($urandom_range(0, 40)) - 32'd10;
            cfg_period   = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 8));
            cfg_cancel   = ($urandom_range(0, 19) == 0);
            ack          = ($urandom_range(0, 4) == 0);
            rst_n        = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
